// File: rtl/systolic_ctrl_if.sv
// Control bundle between the systolic sequencer, the host/DMA and the datapath top.
// master: the sequencer (takes start/reuse_w, drives every enable and strobe).
// slave:  the host/datapath view of the same signals.
interface systolic_ctrl_if;
    logic start;
    logic reuse_w;
    logic input_buffer_load_en;
    logic input_buffer_out_en;
    logic weight_buffer_load_en;
    logic weight_buffer_out_en;
    logic write_weight_en;
    logic output_buffer_load_en;
    logic output_buffer_out_en;
    logic w_req;
    logic a_req;
    logic res_valid;
    logic busy;
    logic done;
    logic w_loaded;

    modport master (
        input  start, reuse_w,
        output input_buffer_load_en, input_buffer_out_en,
        output weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
        output output_buffer_load_en, output_buffer_out_en,
        output w_req, a_req, res_valid, busy, done, w_loaded
    );

    modport slave (
        output start, reuse_w,
        input  input_buffer_load_en, input_buffer_out_en,
        input  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
        input  output_buffer_load_en, output_buffer_out_en,
        input  w_req, a_req, res_valid, busy, done, w_loaded
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic-array top level.
// One tile per start accepted in IDLE: load weights, preload them into the array,
// load activations, stream, capture results, drain results to the host.
// Ports: clk, rst (synchronous, active-high), bus (systolic_ctrl_if.master):
//   start/reuse_w in; buffer/array enables, w_req/a_req, res_valid, busy, done,
//   w_loaded out. All outputs are registered.
module systolic_ctrl #(
    parameter int unsigned ARRAY_W     = 4,
    parameter int unsigned COMPUTE_LAT = 8,
    parameter int unsigned OBUF_LAT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    systolic_ctrl_if.master bus
);
    localparam int unsigned STREAM_LEN = COMPUTE_LAT + ARRAY_W;
    localparam int unsigned CNT_W      = $clog2(STREAM_LEN) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, PRELOAD, LOAD_A, STREAM, DRAIN, DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic ib_load_q, ib_out_q, wb_load_q, wb_out_q, ww_q, ob_load_q, ob_out_q;
    logic busy_q, done_q, w_loaded_q;
    logic ib_load_n, ib_out_n, wb_load_n, wb_out_n, ww_n, ob_load_n, ob_out_n;
    logic busy_n, done_n, w_loaded_n;

    // Next state/counter, then the outputs that belong to the next state so that
    // the registered enables line up exactly with the cycles of their state.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        w_loaded_n = w_loaded_q;
        ib_load_n  = 1'b0;
        ib_out_n   = 1'b0;
        wb_load_n  = 1'b0;
        wb_out_n   = 1'b0;
        ww_n       = 1'b0;
        ob_load_n  = 1'b0;
        ob_out_n   = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.start) begin
                    state_n = (bus.reuse_w && w_loaded_q) ? LOAD_A : LOAD_W;
                end
            end
            LOAD_W: if (cnt == CNT_W'(ARRAY_W - 1)) begin
                state_n = PRELOAD;
                cnt_n   = '0;
            end
            PRELOAD: if (cnt == CNT_W'(ARRAY_W - 1)) begin
                state_n    = LOAD_A;
                cnt_n      = '0;
                w_loaded_n = 1'b1;
            end
            LOAD_A: if (cnt == CNT_W'(ARRAY_W - 1)) begin
                state_n = STREAM;
                cnt_n   = '0;
            end
            STREAM: if (cnt == CNT_W'(STREAM_LEN - 1)) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end
            DRAIN: if (cnt == CNT_W'(ARRAY_W - 1)) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
        unique case (state_n)
            LOAD_W:  wb_load_n = 1'b1;
            PRELOAD: begin
                wb_out_n = 1'b1;
                ww_n     = 1'b1;
            end
            LOAD_A:  ib_load_n = 1'b1;
            STREAM: begin
                // Feed and capture windows; they overlap when COMPUTE_LAT < ARRAY_W.
                ib_out_n  = (cnt_n < CNT_W'(ARRAY_W));
                ob_load_n = (cnt_n >= CNT_W'(COMPUTE_LAT));
            end
            DRAIN:   ob_out_n = 1'b1;
            DONE:    done_n   = 1'b1;
            default: ;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ib_load_q  <= 1'b0;
            ib_out_q   <= 1'b0;
            wb_load_q  <= 1'b0;
            wb_out_q   <= 1'b0;
            ww_q       <= 1'b0;
            ob_load_q  <= 1'b0;
            ob_out_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_loaded_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ib_load_q  <= ib_load_n;
            ib_out_q   <= ib_out_n;
            wb_load_q  <= wb_load_n;
            wb_out_q   <= wb_out_n;
            ww_q       <= ww_n;
            ob_load_q  <= ob_load_n;
            ob_out_q   <= ob_out_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            w_loaded_q <= w_loaded_n;
        end
    end

    // res_valid follows output_buffer_out_en by the output buffer read latency.
    generate
        if (OBUF_LAT == 0) begin : g_rv_direct
            assign bus.res_valid = ob_out_q;
        end else begin : g_rv_pipe
            logic [OBUF_LAT-1:0] rv_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rv_sr <= '0;
                end else begin
                    rv_sr <= (rv_sr << 1) | OBUF_LAT'(ob_out_q);
                end
            end
            assign bus.res_valid = rv_sr[OBUF_LAT-1];
        end
    endgenerate

    assign bus.input_buffer_load_en  = ib_load_q;
    assign bus.input_buffer_out_en   = ib_out_q;
    assign bus.weight_buffer_load_en = wb_load_q;
    assign bus.weight_buffer_out_en  = wb_out_q;
    assign bus.write_weight_en       = ww_q;
    assign bus.output_buffer_load_en = ob_load_q;
    assign bus.output_buffer_out_en  = ob_out_q;
    assign bus.w_req                 = wb_load_q;
    assign bus.a_req                 = ib_load_q;
    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
    assign bus.w_loaded              = w_loaded_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: two instances (COMPUTE_LAT 8 and 2) share stimulus.
// A schedule model marks, per accepted tile, the absolute cycles in which each
// strobe must be high; every cycle both DUTs are compared against it.
module tb_systolic_ctrl;
    localparam int AW  = 4;
    localparam int OL  = 1;
    localparam int KEY = 100000;

    // Bit positions of the observed output vector.
    localparam int B_IBL = 0, B_IBO = 1, B_WBL = 2, B_WBO = 3, B_WW = 4, B_OBL = 5;
    localparam int B_OBO = 6, B_WREQ = 7, B_AREQ = 8, B_RV = 9, B_BUSY = 10, B_DONE = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_ctrl_if bus0 ();
    systolic_ctrl_if bus1 ();

    systolic_ctrl #(.ARRAY_W(AW), .COMPUTE_LAT(8), .OBUF_LAT(OL)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    systolic_ctrl #(.ARRAY_W(AW), .COMPUTE_LAT(2), .OBUF_LAT(OL)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wl_set [2];
    logic [11:0] exp_map [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, expv);
    endtask

    function automatic logic [11:0] get_exp(input int i, input int c);
        int k = i * KEY + c;
        return exp_map.exists(k) ? exp_map[k] : 12'h0;
    endfunction

    function automatic logic wl_exp(input int i, input int c);
        return (wl_set[i] >= 0) && (c >= wl_set[i]);
    endfunction

    task automatic mark(input int i, input int from, input int to, input int b);
        logic [11:0] t;
        for (int c = from; c <= to; c++) begin
            t = get_exp(i, c);
            t[b] = 1'b1;
            exp_map[i * KEY + c] = t;
        end
    endtask

    // Tile accepted with start sampled at the end of cycle c.
    task automatic schedule(input int i, input int c, input bit rw, input int cl);
        bit skip = rw && wl_exp(i, c);
        int base = c + 1;
        int a0, s0, d0;
        if (!skip) begin
            mark(i, base, base + AW - 1, B_WBL);
            mark(i, base, base + AW - 1, B_WREQ);
            mark(i, base + AW, base + 2*AW - 1, B_WBO);
            mark(i, base + AW, base + 2*AW - 1, B_WW);
            if (wl_set[i] < 0) wl_set[i] = base + 2*AW;
        end
        a0 = skip ? base : base + 2*AW;
        s0 = a0 + AW;
        d0 = s0 + cl + AW;
        mark(i, a0, a0 + AW - 1, B_IBL);
        mark(i, a0, a0 + AW - 1, B_AREQ);
        mark(i, s0, s0 + AW - 1, B_IBO);
        mark(i, s0 + cl, s0 + cl + AW - 1, B_OBL);
        mark(i, d0, d0 + AW - 1, B_OBO);
        mark(i, d0 + OL, d0 + OL + AW - 1, B_RV);
        mark(i, d0 + AW, d0 + AW, B_DONE);
        mark(i, base, d0 + AW, B_BUSY);
    endtask

    // Reset during cycle c: nothing scheduled after c survives, weights are lost.
    task automatic reset_model(input int i, input int c);
        int dq[$];
        foreach (exp_map[k]) if ((k / KEY == i) && (k % KEY > c)) dq.push_back(k);
        foreach (dq[j]) exp_map.delete(dq[j]);
        wl_set[i] = -1;
    endtask

    task automatic step(input bit r, input bit s, input bit rw);
        logic [11:0] o0, o1, e;
        @(negedge clk);
        o0 = {bus0.done, bus0.busy, bus0.res_valid, bus0.a_req, bus0.w_req,
              bus0.output_buffer_out_en, bus0.output_buffer_load_en, bus0.write_weight_en,
              bus0.weight_buffer_out_en, bus0.weight_buffer_load_en,
              bus0.input_buffer_out_en, bus0.input_buffer_load_en};
        o1 = {bus1.done, bus1.busy, bus1.res_valid, bus1.a_req, bus1.w_req,
              bus1.output_buffer_out_en, bus1.output_buffer_load_en, bus1.write_weight_en,
              bus1.weight_buffer_out_en, bus1.weight_buffer_load_en,
              bus1.input_buffer_out_en, bus1.input_buffer_load_en};
        check("cl8_outputs", 32'(o0), 32'(get_exp(0, cyc)));
        check("cl8_w_loaded", 32'(bus0.w_loaded), 32'(wl_exp(0, cyc)));
        check("cl2_outputs", 32'(o1), 32'(get_exp(1, cyc)));
        check("cl2_w_loaded", 32'(bus1.w_loaded), 32'(wl_exp(1, cyc)));
        rst          = r;
        bus0.start   = s;
        bus1.start   = s;
        bus0.reuse_w = rw;
        bus1.reuse_w = rw;
        for (int i = 0; i < 2; i++) begin
            e = get_exp(i, cyc);
            if (r) reset_model(i, cyc);
            else if (s && !e[B_BUSY]) schedule(i, cyc, rw, (i == 0) ? 8 : 2);
        end
        cyc++;
    endtask

    initial begin
        wl_set[0] = -1;
        wl_set[1] = -1;
        bus0.start = 1'b0; bus0.reuse_w = 1'b0;
        bus1.start = 1'b0; bus1.reuse_w = 1'b0;

        step(1, 0, 0);
        step(1, 0, 0);
        // Full tile, with start pulses while busy (incl. the DONE cycle) ignored.
        step(0, 1, 0);
        for (int r = 1; r <= 30; r++) step(0, (r == 5 || r == 15 || r == 29), 0);
        // Weight reuse.
        step(0, 1, 1);
        for (int r = 1; r <= 22; r++) step(0, 0, 0);
        // reuse_w right after reset must still load weights.
        step(1, 0, 0);
        step(0, 1, 1);
        for (int r = 1; r <= 30; r++) step(0, 0, 0);
        // Reset mid-tile, then a fresh tile.
        step(0, 1, 0);
        for (int r = 1; r <= 30 + 20; r++) step(r == 18, r == 20, 0);
        // Random traffic.
        for (int r = 0; r < 2000; r++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)));
        for (int r = 0; r < 40; r++) step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the systolic-array top level: input, weight and output buffers plus the array.
- Runs one tile per accepted start pulse: load weights, preload them into the array, load activations, stream activations, capture results, drain results to the host.
- Drives every buffer and array enable of the top level, and host-side request/valid strobes.
- Sits between the host/DMA and the datapath top.

Parameters:
- ARRAY_W, 4: array width; rows per weight, activation and result block.
- COMPUTE_LAT, 8: cycles from first input_buffer_out_en high to first valid out_sum row at output buffer input. Must be ≥1.
- OBUF_LAT, 1: cycles from output_buffer_out_en high to out_res valid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  tile start pulse; sampled only in IDLE
- reuse_w  in  1  with start: skip weight load/preload if weights already resident
- input_buffer_load_en  out  1  input buffer captures in_act
- input_buffer_out_en  out  1  input buffer feeds array
- weight_buffer_load_en  out  1  weight buffer captures in_weight
- weight_buffer_out_en  out  1  weight buffer feeds array
- write_weight_en  out  1  array latches weights
- output_buffer_load_en  out  1  output buffer captures out_sum
- output_buffer_out_en  out  1  output buffer drives out_res
- w_req  out  1  host must present an in_weight row this cycle (equals weight_buffer_load_en)
- a_req  out  1  host must present an in_act row this cycle (equals input_buffer_load_en)
- res_valid  out  1  out_res holds a valid result row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile completion
- w_loaded  out  1  weights resident in the array

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. On rst all outputs are 0, state = IDLE, counters = 0, w_loaded = 0.
- Reset overrides everything, including mid-tile. Buffers are not flushed; the next tile overwrites them.
- All outputs are registered. Each enable is high exactly in the cycles its state is current.
- States, each with a cycle counter cnt that is cleared on entry:
  - IDLE: if start=1, go to LOAD_A when reuse_w=1 and w_loaded=1, else to LOAD_W. start is ignored in all other states.
  - LOAD_W: ARRAY_W cycles, weight_buffer_load_en=w_req=1, then PRELOAD.
  - PRELOAD: ARRAY_W cycles, weight_buffer_out_en=write_weight_en=1. On exit, set w_loaded=1; go to LOAD_A.
  - LOAD_A: ARRAY_W cycles, input_buffer_load_en=a_req=1, then STREAM.
  - STREAM: COMPUTE_LAT+ARRAY_W cycles.
    - input_buffer_out_en=1 for cnt 0..ARRAY_W-1.
    - output_buffer_load_en=1 for cnt COMPUTE_LAT..COMPUTE_LAT+ARRAY_W-1.
    - The two windows may overlap when COMPUTE_LAT<ARRAY_W.
    - Then go to DRAIN.
  - DRAIN: ARRAY_W cycles, output_buffer_out_en=1, then DONE.
  - DONE: one cycle, done=1, then IDLE.
- res_valid: output_buffer_out_en delayed by OBUF_LAT cycles through a shift register cleared on rst. It is exactly ARRAY_W cycles wide and may extend into DONE/IDLE.
- cnt width is clog2(COMPUTE_LAT+ARRAY_W)+1. The counter never wraps within a state; the state exit compare is cnt==len-1.
- A start asserted in the DONE cycle is ignored; start is accepted only in IDLE.
- w_loaded holds across tiles. It is cleared only by rst.

Test Plan:
- ARRAY_W=4, COMPUTE_LAT=8, start at cycle 0, reuse_w=0:
  - w_req cycles 1-4; weight_buffer_out_en and write_weight_en cycles 5-8.
  - a_req cycles 9-12; input_buffer_out_en cycles 13-16.
  - output_buffer_load_en cycles 21-24; output_buffer_out_en cycles 25-28.
  - res_valid cycles 26-29; done cycle 29; busy cycles 1-29; w_loaded=1 from cycle 9.
- Second start with reuse_w=1 after the first tile: a_req cycles 1-4, no w_req or write_weight_en, done at cycle 21 relative.
- reuse_w=1 straight after rst (w_loaded=0): full sequence identical to the first scenario.
- start pulses during busy (cycles 5, 15, 29): ignored; exactly one done per accepted start.
- rst asserted at cycle 18 (in STREAM): all outputs 0 at cycle 19, w_loaded=0, no done. A start at cycle 20 runs the full sequence.
- ARRAY_W=4, COMPUTE_LAT=2: input_buffer_out_en at STREAM cnt 0-3 and output_buffer_load_en at cnt 2-5 overlap at cnt 2-3; STREAM lasts 6 cycles.
